fft_frame_buffer: RTL and testbench



---
 rtl/fft_frame_buffer_if.sv | 11 +
 rtl/fft_frame_buffer.sv | 129 ++++++++++++
 tb/tb_fft_frame_buffer.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_frame_buffer_if.sv
// Sample-stream handshake bundle (data/valid/ready) between the audio source and the framer.
interface fft_frame_buffer_if #(
    parameter int unsigned W = 16
) ();
    logic [W-1:0] data;
    logic         valid;
    logic         ready;

    modport master (output data, output valid, input  ready);
    modport slave  (input  data, input  valid, output ready);
endinterface

// File: rtl/fft_frame_buffer.sv
// Circular sample buffer that emits overlapping NSamples-word frames, advancing Hop samples per frame.
module fft_frame_buffer #(
    parameter int unsigned W        = 16,
    parameter int unsigned NSamples = 1024,
    parameter int unsigned Hop      = 512,
    parameter int unsigned Depth    = 2048
) (
    input  logic                     clk,
    input  logic                     reset,
    fft_frame_buffer_if.slave        audio_input,
    output logic [W-1:0]             fft_input,
    output logic                     fft_input_valid,
    input  logic                     fft_input_ready,
    output logic                     fft_input_first,
    output logic                     fft_input_last,
    output logic                     overrun
);
    localparam int unsigned AW = $clog2(Depth);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned RW = $clog2(NSamples);

    typedef enum logic {IDLE, READ} state_e;

    logic [W-1:0]  mem [Depth];

    state_e        state_q, state_d;
    logic [CW-1:0] wr_cnt_q, wr_cnt_d;
    logic [CW-1:0] frame_start_q, frame_start_d;
    logic [RW-1:0] rd_idx_q, rd_idx_d;
    logic [W-1:0]  dout_q, dout_d;
    logic          valid_q, valid_d;
    logic          first_q, first_d;
    logic          last_q, last_d;
    logic          overrun_q, overrun_d;

    logic [CW-1:0] fill;
    logic [CW-1:0] rd_ptr;
    logic          in_ready;
    logic          wr_en;

    // Occupancy and write acceptance come only from registered counters (wrap mod 2*Depth).
    assign fill              = wr_cnt_q - frame_start_q;
    assign in_ready          = (fill < CW'(Depth));
    assign audio_input.ready = in_ready;
    assign wr_en             = audio_input.valid && in_ready;
    assign rd_ptr            = frame_start_q + CW'(rd_idx_q) + CW'(1);

    assign fft_input       = dout_q;
    assign fft_input_valid = valid_q;
    assign fft_input_first = first_q;
    assign fft_input_last  = last_q;
    assign overrun         = overrun_q;

    // Sample storage; contents need no reset since the counters gate every read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_cnt_q[AW-1:0]] <= audio_input.data;
        end
    end

    // Next-state: write counter, sticky overrun, and the IDLE/READ frame reader.
    always_comb begin
        state_d       = state_q;
        frame_start_d = frame_start_q;
        rd_idx_d      = rd_idx_q;
        dout_d        = dout_q;
        valid_d       = valid_q;
        first_d       = first_q;
        last_d        = last_q;
        wr_cnt_d      = wr_en ? (wr_cnt_q + CW'(1)) : wr_cnt_q;
        overrun_d     = overrun_q | (audio_input.valid & ~in_ready);

        case (state_q)
            IDLE: begin
                if (fill >= CW'(NSamples)) begin
                    dout_d   = mem[frame_start_q[AW-1:0]];
                    valid_d  = 1'b1;
                    first_d  = 1'b1;
                    last_d   = 1'b0;
                    rd_idx_d = '0;
                    state_d  = READ;
                end
            end
            READ: begin
                if (fft_input_ready) begin
                    if (rd_idx_q != RW'(NSamples - 1)) begin
                        rd_idx_d = rd_idx_q + RW'(1);
                        dout_d   = mem[rd_ptr[AW-1:0]];
                        first_d  = 1'b0;
                        last_d   = (rd_idx_q == RW'(NSamples - 2));
                    end else begin
                        // Word stays on the bus; only valid drops so the data register holds.
                        frame_start_d = frame_start_q + CW'(Hop);
                        valid_d       = 1'b0;
                        first_d       = 1'b0;
                        last_d        = 1'b0;
                        state_d       = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and counter registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            wr_cnt_q      <= '0;
            frame_start_q <= '0;
            rd_idx_q      <= '0;
            dout_q        <= '0;
            valid_q       <= 1'b0;
            first_q       <= 1'b0;
            last_q        <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_cnt_q      <= wr_cnt_d;
            frame_start_q <= frame_start_d;
            rd_idx_q      <= rd_idx_d;
            dout_q        <= dout_d;
            valid_q       <= valid_d;
            first_q       <= first_d;
            last_q        <= last_d;
            overrun_q     <= overrun_d;
        end
    end
endmodule

// File: tb/tb_fft_frame_buffer.sv
// Scoreboard bench: stimulus pushes expected frame words, a negedge monitor pops on each handshake.
module tb_fft_frame_buffer;
    typedef struct packed {
        logic        first;
        logic        last;
        logic [15:0] data;
    } exp_t;

    logic clk, rst;
    logic fft_rdy;
    bit   sel;
    logic [15:0] src_data;
    logic src_valid, src_ready;

    logic [15:0] a_data, b_data, m_data;
    logic a_valid, a_first, a_last, a_ovr;
    logic b_valid, b_first, b_last, b_ovr;
    logic m_valid, m_first, m_last;

    fft_frame_buffer_if #(.W(16)) a_if ();
    fft_frame_buffer_if #(.W(16)) b_if ();

    fft_frame_buffer #(.W(16), .NSamples(8), .Hop(4), .Depth(16)) dut_a (
        .clk(clk), .reset(rst), .audio_input(a_if),
        .fft_input(a_data), .fft_input_valid(a_valid), .fft_input_ready(fft_rdy),
        .fft_input_first(a_first), .fft_input_last(a_last), .overrun(a_ovr));

    fft_frame_buffer #(.W(16), .NSamples(8), .Hop(8), .Depth(16)) dut_b (
        .clk(clk), .reset(rst), .audio_input(b_if),
        .fft_input(b_data), .fft_input_valid(b_valid), .fft_input_ready(fft_rdy),
        .fft_input_first(b_first), .fft_input_last(b_last), .overrun(b_ovr));

    assign a_if.data  = src_data;
    assign b_if.data  = src_data;
    assign a_if.valid = src_valid & ~sel;
    assign b_if.valid = src_valid & sel;
    assign src_ready  = sel ? b_if.ready : a_if.ready;
    assign m_data     = sel ? b_data  : a_data;
    assign m_valid    = sel ? b_valid : a_valid;
    assign m_first    = sel ? b_first : a_first;
    assign m_last     = sel ? b_last  : a_last;

    exp_t exp_q[$];
    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int acc_cnt = 0;
    bit src_busy = 0;
    bit abort_src = 0;
    bit chk_gap = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: pops on each handshake, checks hold under backpressure and inter-frame gap.
    bit   have_last = 0;
    int   last_cyc = 0;
    bit   hold_pend = 0;
    logic [15:0] hold_val;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            have_last = 0;
            hold_pend = 0;
        end else begin
            if (hold_pend) check("hold", {15'd0, m_valid, m_data}, {15'd0, 1'b1, hold_val});
            hold_pend = m_valid && !fft_rdy;
            hold_val  = m_data;
            if (m_valid && fft_rdy) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL extra_word: got 0x%0h, expected no word (cycle %0d)", m_data, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("word", 32'({m_first, m_last, m_data}), 32'(e));
                    if (m_first && chk_gap && have_last) check("gap", 32'(cyc - last_cyc), 32'd2);
                    if (m_last) begin
                        have_last = 1;
                        last_cyc  = cyc;
                    end
                end
            end
        end
    end

    task automatic push_frame(input int start);
        for (int i = 0; i < 8; i++) exp_q.push_back({(i == 0), (i == 7), 16'(start + i)});
    endtask

    task automatic send(input logic [15:0] d, output bit ok);
        ok = 0;
        src_data  = d;
        src_valid = 1'b1;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (src_ready) begin
                ok = 1;
                break;
            end
        end
        @(posedge clk); #1;
        src_valid = 1'b0;
        if (ok) acc_cnt++;
    endtask

    task automatic src_ramp(input int base, input int n, input int gap);
        bit ok;
        src_busy = 1;
        for (int i = 0; i < n; i++) begin
            if (abort_src) break;
            send(16'(base + i), ok);
            if (!ok) check("src_accept", 32'(ok), 32'd1);
            repeat (gap) begin @(posedge clk); #1; end
        end
        src_busy = 0;
    endtask

    task automatic check_rst(input string tag);
        @(negedge clk);
        check({tag, "_data"},  32'(a_data),  32'd0);
        check({tag, "_valid"}, 32'(a_valid), 32'd0);
        check({tag, "_first"}, 32'(a_first), 32'd0);
        check({tag, "_last"},  32'(a_last),  32'd0);
        check({tag, "_ovr"},   32'(a_ovr),   32'd0);
        check({tag, "_ready"}, 32'(a_if.ready), 32'd1);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        abort_src = 1;
        @(posedge clk); #1;
        check_rst(tag);
        for (int n = 0; n < 500 && src_busy; n++) @(posedge clk);
        check({tag, "_src_idle"}, 32'(src_busy), 32'd0);
        @(posedge clk); #1;
        exp_q.delete();
        acc_cnt   = 0;
        abort_src = 0;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic wait_drain(input string nm);
        for (int n = 0; n < 600 && exp_q.size() != 0; n++) begin @(posedge clk); #1; end
        repeat (6) begin @(posedge clk); #1; end
        check(nm, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_word(input logic [15:0] v, output bit ok);
        ok = 0;
        for (int n = 0; n < 600; n++) begin
            @(posedge clk); #1;
            if (a_valid && a_data == v) begin
                ok = 1;
                break;
            end
        end
    endtask

    initial begin
        repeat (30000) @(posedge clk);
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        rst = 1'b1; fft_rdy = 1'b1; sel = 0; src_valid = 1'b0; src_data = '0;
        repeat (2) @(posedge clk); #1;
        do_reset("init");

        // Continuous ramp with overlapping frames and one idle cycle between them.
        chk_gap = 1;
        push_frame(0); push_frame(4); push_frame(8); push_frame(12);
        src_ramp(0, 20, 0);
        wait_drain("cont_drain");
        chk_gap = 0;

        // Backpressure for 3 cycles at word 3 of frame 0.
        do_reset("bp");
        push_frame(0);
        fork src_ramp(0, 8, 0); join_none
        wait_word(16'd3, ok);
        check("bp_seen3", 32'(ok), 32'd1);
        fft_rdy = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("bp_hold3", 32'(a_data), 32'd3);
        fft_rdy = 1'b1;
        wait_drain("bp_drain");

        // Buffer full with the reader stalled.
        do_reset("full");
        fft_rdy = 1'b0;
        push_frame(0); push_frame(4); push_frame(8); push_frame(12);
        src_ramp(0, 16, 0);
        check("full_ready_low", 32'(a_if.ready), 32'd0);
        check("full_ovr_pre", 32'(a_ovr), 32'd0);
        fork src_ramp(16, 4, 0); join_none
        repeat (5) begin @(posedge clk); #1; end
        check("full_acc16", 32'(acc_cnt), 32'd16);
        check("full_ovr", 32'(a_ovr), 32'd1);
        check("full_ready_still_low", 32'(a_if.ready), 32'd0);
        fft_rdy = 1'b1;
        for (int n = 0; n < 200 && src_busy; n++) begin @(posedge clk); #1; end
        check("full_acc20", 32'(acc_cnt), 32'd20);
        wait_drain("full_drain");

        // No overlap: Hop equals NSamples.
        sel = 1;
        do_reset("nohop");
        push_frame(0); push_frame(8);
        src_ramp(0, 16, 0);
        wait_drain("nohop_drain");
        check("nohop_ovr", 32'(b_ovr), 32'd0);
        sel = 0;

        // Reset at word 5 of frame 1, then a fresh ramp from 100.
        do_reset("pre_mid");
        push_frame(0);
        for (int i = 0; i < 5; i++) exp_q.push_back({(i == 0), 1'b0, 16'(4 + i)});
        fork src_ramp(0, 20, 0); join_none
        wait_word(16'd9, ok);
        check("mid_seen9", 32'(ok), 32'd1);
        rst = 1'b1;
        check("mid_queue", 32'(exp_q.size()), 32'd0);
        do_reset("mid");
        push_frame(100);
        src_ramp(100, 8, 0);
        wait_drain("mid_drain");

        // Late source: one sample every 10 cycles; first word 2 cycles after the 8th.
        do_reset("late");
        push_frame(0);
        for (int i = 0; i < 8; i++) begin
            send(16'(i), ok);
            if (!ok) check("late_accept", 32'(ok), 32'd1);
            if (i == 7) begin
                check("late_t1_valid", 32'(a_valid), 32'd0);
                @(posedge clk); #1;
                check("late_t2_word", {14'd0, a_valid, a_first, a_data}, {14'd0, 1'b1, 1'b1, 16'd0});
            end else begin
                repeat (9) begin @(posedge clk); #1; end
            end
        end
        wait_drain("late_drain");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
